// File: rtl/pad_serial_pkg.sv
// Shared state encoding, default bit timing and frame-length constants for pad_serial_xcvr.
// Defining PAD_SERIAL_PARITY_EN adds an even-parity bit between data bit 7 and the stop bit.
package pad_serial_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_TURN_CYCLES  = 2;

  localparam int DATA_BITS = 8;
`ifdef PAD_SERIAL_PARITY_EN
  localparam int PAYLOAD_BITS = DATA_BITS + 1;
`else
  localparam int PAYLOAD_BITS = DATA_BITS;
`endif
  // start + payload + stop
  localparam int FRAME_BITS = PAYLOAD_BITS + 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_TX_START = 3'd1;
  localparam state_t ST_TX_DATA  = 3'd2;
  localparam state_t ST_TX_STOP  = 3'd3;
  localparam state_t ST_TX_TURN  = 3'd4;
  localparam state_t ST_RX_START = 3'd5;
  localparam state_t ST_RX_DATA  = 3'd6;
  localparam state_t ST_RX_STOP  = 3'd7;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pad_serial_xcvr_sync.sv
// Two-flop synchronizer for the asynchronous pad input plus a falling-edge strobe.
// Flops reset to 1 so the idle-high line never produces a spurious edge after reset.
module pad_sync (
  input  logic clk,
  input  logic reset,
  input  logic pad_di,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pad_di;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/pad_serial_xcvr.sv
// Half-duplex single-pin serial transceiver driving a bidirectional pad cell (DO/OEN/DI).
// PAD_SERIAL_PARITY_EN compiles in an even-parity bit on both transmit and receive.
module pad_serial_xcvr
  import pad_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TURN_CYCLES  = DEF_TURN_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       pad_do,
  output logic       pad_oen,
  input  logic       pad_di
);

  localparam int BIT_CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int TURN_CNT_W = $clog2(TURN_CYCLES + 1);
  // One counter serves bit timing and the turnaround hold, so size it for the larger.
  localparam int CNT_W = (BIT_CNT_W > TURN_CNT_W) ? BIT_CNT_W : TURN_CNT_W;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [3:0]       PAY_LAST  = 4'(PAYLOAD_BITS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [PAYLOAD_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [7:0]              rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_err_q, rx_err_d;
  logic                    pad_do_q, pad_do_d;
  logic                    pad_oen_q, pad_oen_d;

  logic                    rx_sync;
  logic                    rx_fall;
  logic                    rx_par_ok;
  logic [PAYLOAD_BITS-1:0] tx_payload;

  pad_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pad_di (pad_di),
    .sync_o (rx_sync),
    .fall_o (rx_fall)
  );

`ifdef PAD_SERIAL_PARITY_EN
  assign tx_payload = {even_parity(tx_data), tx_data};
  assign rx_par_ok  = (rx_shift_q[DATA_BITS] == even_parity(rx_shift_q[DATA_BITS-1:0]));
`else
  assign tx_payload = tx_data;
  assign rx_par_ok  = 1'b1;
`endif

  assign tx_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    pad_do_d   = pad_do_q;
    pad_oen_d  = pad_oen_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        idx_d     = '0;
        pad_do_d  = 1'b1;
        pad_oen_d = 1'b0;
        // A handshake beats a start edge seen in the same cycle.
        if (tx_valid && tx_ready) begin
          state_d    = ST_TX_START;
          tx_shift_d = tx_payload;
          pad_oen_d  = 1'b1;
          pad_do_d   = 1'b0;
        end else if (rx_fall) begin
          state_d = ST_RX_START;
        end
      end

      ST_TX_START: begin
        if (cnt_q == BIT_LAST) begin
          state_d    = ST_TX_DATA;
          cnt_d      = '0;
          pad_do_d   = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[PAYLOAD_BITS-1:1]};
        end
      end

      ST_TX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == PAY_LAST) begin
            state_d  = ST_TX_STOP;
            pad_do_d = 1'b1;
          end else begin
            idx_d      = idx_q + 1'b1;
            pad_do_d   = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[PAYLOAD_BITS-1:1]};
          end
        end
      end

      ST_TX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          state_d = ST_TX_TURN;
          cnt_d   = '0;
        end
      end

      // Hold the line driven high briefly so the far end sees a clean stop before release.
      ST_TX_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          pad_oen_d = 1'b0;
        end
      end

      ST_RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync ? ST_IDLE : ST_RX_DATA;
        end
      end

      ST_RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          rx_shift_d = {rx_sync, rx_shift_q[PAYLOAD_BITS-1:1]};
          if (idx_q == PAY_LAST) begin
            state_d = ST_RX_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (rx_sync && rx_par_ok) begin
            rx_data_d  = rx_shift_q[7:0];
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pad_do_d  = 1'b1;
        pad_oen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      pad_do_q   <= 1'b1;
      pad_oen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      pad_do_q   <= pad_do_d;
      pad_oen_q  <= pad_oen_d;
    end
  end

  // Shift registers are always fully loaded before use and need no reset.
  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign pad_do   = pad_do_q;
  assign pad_oen  = pad_oen_q;

endmodule

// File: tb/tb_pad_serial_xcvr.sv
// Self-checking bench for pad_serial_xcvr: frame-level reference model, random bytes and glitches.
module tb_pad_serial_xcvr;

  localparam int C    = 16;
  localparam int TURN = 2;
`ifdef PAD_SERIAL_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       pad_do;
  logic       pad_oen;
  logic       pad_di;
  logic       line_drv;

  int checks = 0;
  int errors = 0;
  int n_rxv, n_rxe, n_both;
  logic [7:0] exp_rx_data;

  // Shared line: transceiver drives when enabled, otherwise the remote end / pull-up.
  assign pad_di = pad_oen ? pad_do : line_drv;

  always #5 clk = ~clk;

  pad_serial_xcvr #(.CLKS_PER_BIT(C), .TURN_CYCLES(TURN)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .pad_do   (pad_do),
    .pad_oen  (pad_oen),
    .pad_di   (pad_di)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  // Bit k of a frame: start 0, data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop,
                                     input logic pflip);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == FB - 1) return stop;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return logic'(ones % 2) ^ pflip;
  endfunction

  task automatic step();
    @(negedge clk);
    if (rx_valid) n_rxv++;
    if (rx_err) n_rxe++;
    if (rx_valid && rx_err) n_both++;
  endtask

  task automatic clr_counts();
    n_rxv = 0;
    n_rxe = 0;
    n_both = 0;
  endtask

  // Called on the first sample after the handshake edge.
  task automatic check_tx_frame(input logic [7:0] d, input string tag);
    int oen_cnt;
    int bad;
    logic e;
    oen_cnt = 0;
    for (int k = 0; k < FB; k++) begin
      bad = 0;
      e = frame_bit(d, k, 1'b1, 1'b0);
      for (int c = 0; c < C; c++) begin
        if (pad_oen) oen_cnt++;
        if (pad_oen !== 1'b1 || pad_do !== e || tx_ready !== 1'b0 || rx_valid || rx_err) bad++;
        step();
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s tx_bit%0d: %0d wrong cycles, required pad_do=%b pad_oen=1 tx_ready=0",
                 tag, k, bad, e);
      end
    end
    bad = 0;
    for (int c = 0; c < TURN; c++) begin
      if (pad_oen) oen_cnt++;
      if (pad_oen !== 1'b1 || pad_do !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s turnaround: %0d wrong cycles, required pad_do=1 pad_oen=1", tag, bad);
    end
    for (int c = 0; c < 8 && pad_oen === 1'b1; c++) begin
      oen_cnt++;
      step();
    end
    checks++;
    if (oen_cnt != FB * C + TURN) begin
      errors++;
      $display("FAIL %s oen_cycles: got %0d, required %0d", tag, oen_cnt, FB * C + TURN);
    end
    checks++;
    if (pad_oen !== 1'b0 || pad_do !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s tx_end: oen=%b do=%b ready=%b, required 0 1 1", tag, pad_oen, pad_do,
               tx_ready);
    end
  endtask

  task automatic tx_send(input logic [7:0] d, input string tag);
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 4 * FB * C) begin
      step();
      w++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s tx_ready_wait: tx_ready=%b, required 1", tag, tx_ready);
    end else begin
      tx_data  = d;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      check_tx_frame(d, tag);
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic pflip,
                          input logic hold_tx, input logic [7:0] tx_byte, input string tag);
    logic good;
    int   tr_bad;
    int   accepted;
    good = stop && !pflip;
    tr_bad = 0;
    accepted = 0;
    clr_counts();
    for (int k = 0; k < FB - 1; k++) begin
      line_drv = frame_bit(d, k, stop, pflip);
      if (hold_tx && k == 1) begin
        tx_data  = tx_byte;
        tx_valid = 1'b1;
      end
      for (int c = 0; c < C; c++) begin
        step();
        if (hold_tx && k >= 1 && tx_ready !== 1'b0) tr_bad++;
      end
    end
    line_drv = stop;
    for (int c = 0; c < 2 * C; c++) begin
      step();
      if (hold_tx && tx_ready === 1'b1) begin
        accepted = 1;
        break;
      end
      if (c == C - 1) line_drv = 1'b1;
    end
    if (hold_tx) begin
      checks++;
      if (tr_bad != 0) begin
        errors++;
        $display("FAIL %s ready_during_rx: %0d cycles high, required 0", tag, tr_bad);
      end
      checks++;
      if (accepted == 0) begin
        errors++;
        $display("FAIL %s held_tx_accept: tx_ready never 1 after rx, required 1", tag);
        tx_valid = 1'b0;
      end else begin
        step();
        tx_valid = 1'b0;
        line_drv = 1'b1;
        check_tx_frame(tx_byte, tag);
      end
    end
    line_drv = 1'b1;
    for (int c = 0; c < C; c++) step();
    if (good) exp_rx_data = d;
    checks++;
    if (n_rxv != (good ? 1 : 0) || n_rxe != (good ? 0 : 1)) begin
      errors++;
      $display("FAIL %s rx_pulses: rx_valid=%0d rx_err=%0d, required %0d %0d", tag, n_rxv, n_rxe,
               good ? 1 : 0, good ? 0 : 1);
    end
    checks++;
    if (rx_data !== exp_rx_data) begin
      errors++;
      $display("FAIL %s rx_data: got %02h, required %02h", tag, rx_data, exp_rx_data);
    end
    checks++;
    if (n_both != 0) begin
      errors++;
      $display("FAIL %s rx_overlap: %0d cycles with both pulses, required 0", tag, n_both);
    end
  endtask

  task automatic glitch(input int len, input string tag);
    clr_counts();
    line_drv = 1'b0;
    for (int c = 0; c < len; c++) step();
    line_drv = 1'b1;
    for (int c = 0; c < 2 * C; c++) step();
    checks++;
    if (n_rxv != 0 || n_rxe != 0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s glitch: rx_valid=%0d rx_err=%0d ready=%b, required 0 0 1", tag, n_rxv,
               n_rxe, tx_ready);
    end
    checks++;
    if (rx_data !== exp_rx_data) begin
      errors++;
      $display("FAIL %s glitch_rx_data: got %02h, required %02h", tag, rx_data, exp_rx_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (pad_oen !== 1'b0 || pad_do !== 1'b1 || rx_data !== 8'h00 || rx_valid !== 1'b0 ||
        rx_err !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: oen=%b do=%b rx_data=%02h vld=%b err=%b ready=%b, required 0 1 00 0 0 1",
               pad_oen, pad_do, rx_data, rx_valid, rx_err, tx_ready);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_tx_a5();
    tx_send(8'hA5, "tx_a5");
  endtask

  task automatic test_rx_3c();
    rx_frame(8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, "rx_3c");
    rx_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, "rx_3c_stop0");
  endtask

  task automatic test_glitch();
    glitch(4, "glitch4");
  endtask

  task automatic test_reset_mid_tx();
    clr_counts();
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int c = 0; c < 49; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rx_data = 8'h00;
    checks++;
    if (pad_oen !== 1'b0 || pad_do !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_tx: oen=%b do=%b ready=%b, required 0 1 1", pad_oen, pad_do,
               tx_ready);
    end
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (n_rxv != 0 || n_rxe != 0) begin
      errors++;
      $display("FAIL reset_mid_tx_pulses: rx_valid=%0d rx_err=%0d, required 0 0", n_rxv, n_rxe);
    end
    tx_send(8'h01, "tx_after_reset");
  endtask

  task automatic test_reset_mid_rx();
    clr_counts();
    for (int k = 0; k < 4; k++) begin
      line_drv = frame_bit(8'h5A, k, 1'b1, 1'b0);
      for (int c = 0; c < C; c++) step();
    end
    reset = 1'b1;
    line_drv = 1'b1;
    step();
    reset = 1'b0;
    exp_rx_data = 8'h00;
    for (int c = 0; c < FB * C; c++) step();
    checks++;
    if (n_rxv != 0 || n_rxe != 0 || rx_data !== 8'h00 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_rx: rx_valid=%0d rx_err=%0d rx_data=%02h ready=%b, required 0 0 00 1",
               n_rxv, n_rxe, rx_data, tx_ready);
    end
  endtask

  task automatic test_rx_hold_tx();
    rx_frame(8'hC3, 1'b1, 1'b0, 1'b1, 8'h96, "rx_hold_tx");
  endtask

  task automatic test_tx_wins_edge();
    clr_counts();
    line_drv = 1'b0;
    step();
    step();
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_wins_ready: tx_ready=%b, required 1", tx_ready);
    end
    tx_data  = 8'h6E;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    line_drv = 1'b1;
    check_tx_frame(8'h6E, "tx_wins_edge");
    for (int c = 0; c < 2 * C; c++) step();
    checks++;
    if (n_rxv != 0 || n_rxe != 0) begin
      errors++;
      $display("FAIL tx_wins_pulses: rx_valid=%0d rx_err=%0d, required 0 0", n_rxv, n_rxe);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    logic       pflip;
    for (int i = 0; i < 4; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
`ifdef PAD_SERIAL_PARITY_EN
      pflip = ($urandom_range(0, 3) == 0);
`else
      pflip = 1'b0;
`endif
      rx_frame(d, stop, pflip, 1'b0, 8'h00, "rand_rx");
      for (int c = 0; c < int'($urandom_range(0, 5)); c++) step();
      tx_send(8'($urandom), "rand_tx");
      glitch(int'($urandom_range(1, 5)), "rand_glitch");
    end
  endtask

`ifdef PAD_SERIAL_PARITY_EN
  task automatic test_parity();
    rx_frame(8'h07, 1'b1, 1'b1, 1'b0, 8'h00, "rx_parity_bad");
    tx_send(8'h07, "tx_parity");
  endtask
`endif

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    line_drv = 1'b1;
    exp_rx_data = 8'h00;
    clr_counts();
    test_reset();
    test_tx_a5();
    test_rx_3c();
    test_glitch();
    test_reset_mid_tx();
    test_rx_hold_tx();
    test_tx_wins_edge();
    test_random();
    test_reset_mid_rx();
`ifdef PAD_SERIAL_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_serial_xcvr.md
PAD_SERIAL_XCVR -- requirements
Module: pad_serial_xcvr

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, is the clock cycles per serial bit (even, >=4).
REQ-002 Parameter TURN_CYCLES, default 2, is the cycles the driver is held on after the stop bit before release (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  8  byte to transmit.
REQ-006 tx_valid  input  1  tx_data valid.
REQ-007 tx_ready  output  1  transceiver accepts a byte (combinational, high only in IDLE).
REQ-008 rx_data  output  8  last received byte; held until next good frame.
REQ-009 rx_valid  output  1  one-cycle pulse, rx_data new.
REQ-010 rx_err  output  1  one-cycle pulse, framing error (or parity error, REQ-030).
REQ-011 pad_do  output  1  data to pad cell DO.
REQ-012 pad_oen  output  1  pad cell output enable (1 = drive line).
REQ-013 pad_di  input  1  pad cell DI, asynchronous to clk.

Function
REQ-014 Frame: start bit 0, 8 data bits LSB first, stop bit 1; line idles high via external pull-up with pad_oen=0.
REQ-015 States: IDLE, TX_START, TX_DATA, TX_STOP, TX_TURN, RX_START, RX_DATA, RX_STOP.
REQ-016 Handshake tx_valid&&tx_ready latches tx_data; next cycle pad_oen=1, pad_do=0 (TX_START).
REQ-017 Each bit is driven exactly CLKS_PER_BIT cycles; TX_STOP drives 1; TX_TURN keeps pad_oen=1, pad_do=1 for TURN_CYCLES, then IDLE with pad_oen=0.
REQ-018 pad_oen high for exactly 10*CLKS_PER_BIT+TURN_CYCLES cycles per byte; pad_do and pad_oen are registered outputs.
REQ-019 pad_di passes a 2-flop synchronizer; a synchronized 1->0 transition in IDLE with no handshake that cycle enters RX_START.
REQ-020 Handshake and falling edge in the same cycle: TX wins; the edge is ignored.
REQ-021 RX_START re-samples at CLKS_PER_BIT/2; if 1, return to IDLE with no rx_valid/rx_err (glitch reject).
REQ-022 Data and stop bits sampled once each, every CLKS_PER_BIT cycles after the mid-start sample.
REQ-023 Stop sample 1: rx_data updated, rx_valid pulses next cycle; stop sample 0: rx_err pulses, rx_data unchanged; both return to IDLE.
REQ-024 Receiver is inert while pad_oen=1 and throughout TX_TURN (own transmission never received).
REQ-025 tx_ready=0 in every state except IDLE; tx_valid held during RX is accepted only after RX completes.
REQ-026 rx_valid and rx_err never assert in the same cycle.

Reset
REQ-027 On reset: state IDLE, pad_oen=0, pad_do=1, rx_data=0, rx_valid=0, rx_err=0, synchronizer flops=1, counters=0.
REQ-028 Reset mid-frame aborts it: pad_oen=0 the cycle after reset is sampled, no partial rx_valid/rx_err.

Configuration
REQ-029 Macro PAD_SERIAL_PARITY_EN compiles in an even-parity bit between bit 7 and stop (11-bit frame, pad_oen high 11*CLKS_PER_BIT+TURN_CYCLES).
REQ-030 With PAD_SERIAL_PARITY_EN, received parity mismatch pulses rx_err with no rx_valid; without it, frames are 10 bits and no parity logic exists.

Structure
REQ-031 Package pad_serial_pkg holds the state enum, default CLKS_PER_BIT/TURN_CYCLES, and frame-length constants.
REQ-032 Sub-module pad_sync: 2-flop synchronizer plus falling-edge detect; bit-cycle counter width clog2(CLKS_PER_BIT).

Verification (CLKS_PER_BIT=16, TURN_CYCLES=2)
REQ-033 TX 0xA5 -> pad_do 0,1,0,1,0,0,1,0,1,1 each 16 cycles, pad_oen high 162 cycles, tx_ready high again after.
REQ-034 Drive pad_di frame 0x3C -> one rx_valid pulse, rx_data=0x3C, rx_err=0.
REQ-035 Frame 0x3C with stop bit 0 -> rx_err pulse, rx_data keeps prior value, no rx_valid.
REQ-036 pad_di low 4 cycles in IDLE -> no rx_valid/rx_err, returns IDLE, tx_ready=1.
REQ-037 Reset at cycle 50 of TX 0xFF -> pad_oen=0, pad_do=1 next cycle; next tx 0x01 transmits correctly.
REQ-038 PAD_SERIAL_PARITY_EN: RX 0x07 with parity bit 0 -> rx_err pulse; TX 0x07 -> parity bit 1, pad_oen high 178 cycles.
